// File: rtl/multi_read_port_ram_pkg.sv
// multi_read_port_ram_pkg: shared state encoding, byte-count helper and port-count limits
package multi_read_port_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int NRD_MIN = 1;
    localparam int NRD_MAX = 8;

    function automatic int nbytes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/multi_read_port_ram_read_port.sv
// ram_read_port: one registered read port with enable hold, zero-lock and write bypass merge
module ram_read_port
    import multi_read_port_ram_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ready,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    input  logic [DW-1:0]         word,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DW-1:0]         wdata,
    input  logic [nbytes(DW)-1:0] wbe,
    output logic [DW-1:0]         rdata
);

    logic [DW-1:0] merged;
    logic [DW-1:0] rd_nxt;
    logic          hit;

    assign hit = (BYPASS != 0) && we && (waddr == raddr);

    // Stored word overlaid with the enabled bytes of a same-cycle write
    always_comb begin
        merged = word;
        for (int b = 0; b < nbytes(DW); b++)
            if (wbe[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        rd_nxt = (ZERO_REG0 != 0 && raddr == '0) ? '0 : hit ? merged : word;
    end

    // Output register: only loads on an enabled read once the array is cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (ready && re) rdata <= rd_nxt;
    end

endmodule

// File: rtl/multi_read_port_ram.sv
// multi_read_port_ram: byte-enabled register-file RAM with NRD registered read ports and a post-reset clear sequencer
module multi_read_port_ram
    import multi_read_port_ram_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int NRD       = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DW-1:0]         i_wdata,
    input  logic [nbytes(DW)-1:0] i_wbe,
    input  logic [NRD-1:0]        i_re,
    input  logic [NRD*AW-1:0]     i_raddr,
    output logic [NRD*DW-1:0]     o_rdata,
    output logic                  o_ready
);

    localparam int DEPTH = 2 ** AW;

    if (NRD < NRD_MIN || NRD > NRD_MAX || DW % 8 != 0) begin : g_bad_params
        $error("multi_read_port_ram: unsupported NRD or DW");
    end

    state_t        state;
    state_t        state_nxt;
    logic [AW:0]   clr_cnt;
    logic [AW:0]   clr_nxt;
    logic          wr_en;
    logic [DW-1:0] wr_word;
    logic [DW-1:0] mem [0:DEPTH-1];

    // The extra counter bit flags that the last entry has just been cleared
    assign clr_nxt = clr_cnt + 1'b1;
    assign wr_en   = (state == ST_READY) && i_we && !(ZERO_REG0 != 0 && i_waddr == '0);
    assign o_ready = (state == ST_READY);

    // Byte merge of the incoming write into the currently stored word
    always_comb begin
        wr_word = mem[i_waddr];
        for (int b = 0; b < nbytes(DW); b++)
            if (i_wbe[b]) wr_word[8*b +: 8] = i_wdata[8*b +: 8];
    end

    // Clear FSM next state: leave CLEAR after the final entry is zeroed
    always_comb begin
        state_nxt = (state == ST_CLEAR && clr_nxt[AW]) ? ST_READY : state;
    end

    // Clear FSM state and counter; READY is terminal until the next reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= (state == ST_CLEAR) ? clr_nxt : clr_cnt;
        end
    end

    // Array write: clear sequencer owns the port until READY, then user writes
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) mem[clr_cnt[AW-1:0]] <= '0;
        else if (wr_en) mem[i_waddr] <= wr_word;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        ram_read_port #(
            .DW       (DW),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG0(ZERO_REG0)
        ) u_rd (
            .clk  (clk),
            .rst  (rst),
            .ready(o_ready),
            .re   (i_re[k]),
            .raddr(i_raddr[k*AW +: AW]),
            .word (mem[i_raddr[k*AW +: AW]]),
            .we   (i_we),
            .waddr(i_waddr),
            .wdata(i_wdata),
            .wbe  (i_wbe),
            .rdata(o_rdata[k*DW +: DW])
        );
    end

endmodule

// File: tb/tb_multi_read_port_ram.sv
// tb_multi_read_port_ram: directed bench for a default instance and a BYPASS=0, NRD=4 instance
module tb_multi_read_port_ram;

    logic         clk;
    logic         rst;
    logic         we;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic [3:0]   wbe;
    logic [1:0]   re;
    logic [9:0]   raddr;
    logic [63:0]  rdata;
    logic         ready;
    logic [3:0]   re_b;
    logic [19:0]  raddr_b;
    logic [127:0] rdata_b;
    logic         ready_b;
    int           errors;
    int           checks;

    multi_read_port_ram dut (
        .clk(clk), .rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_wbe(wbe),
        .i_re(re), .i_raddr(raddr), .o_rdata(rdata), .o_ready(ready)
    );

    multi_read_port_ram #(.NRD(4), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .i_wbe(wbe),
        .i_re(re_b), .i_raddr(raddr_b), .o_rdata(rdata_b), .o_ready(ready_b)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; wbe = 4'h0; re = 2'b00; re_b = 4'h0;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        idle();
        we = 1; waddr = a; wdata = d; wbe = be;
        step();
        we = 0;
    endtask

    task automatic wait_clear(input string tag);
        for (int i = 1; i <= 32; i++) begin
            step();
            checks++;
            if (ready !== (i == 32) || ready_b !== (i == 32)) begin
                errors++;
                $display("FAIL %s_ready edge %0d: got %b/%b want %b", tag, i, ready, ready_b, i == 32);
            end
        end
    endtask

    task automatic read_all_zero(input string tag, input int last);
        for (int a = 0; a <= last; a++) begin
            idle();
            re = 2'b11; raddr = {a[4:0], a[4:0]};
            re_b = 4'b0001; raddr_b = {15'd0, a[4:0]};
            step();
            checks++;
            if (rdata !== 64'd0 || rdata_b[31:0] !== 32'd0) begin
                errors++;
                $display("FAIL %s addr %0d: got %h/%h want 0", tag, a, rdata, rdata_b[31:0]);
            end
        end
        idle();
    endtask

    task automatic test_reset();
        rst = 1; idle(); waddr = 0; wdata = 0; raddr = 0; raddr_b = 0;
        step();
        step();
        checks++;
        if (ready !== 1'b0 || rdata !== 64'd0 || rdata_b !== 128'd0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b rdata=%h want 0", ready, rdata);
        end
        rst = 0;
        wait_clear("clear");
        read_all_zero("clear_read", 31);
    endtask

    task automatic test_write_read();
        write(5'd5, 32'hDEADBEEF, 4'hF);
        re = 2'b11; raddr = {5'd5, 5'd5};
        re_b = 4'b0001; raddr_b = {15'd0, 5'd5};
        step();
        checks++;
        if (rdata !== {2{32'hDEADBEEF}} || rdata_b[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_read: got %h/%h want deadbeef", rdata, rdata_b[31:0]);
        end
        idle();
    endtask

    task automatic test_byte_enable();
        idle();
        we = 1; waddr = 5'd5; wdata = 32'h11223344; wbe = 4'b0101;
        re = 2'b11; raddr = {5'd5, 5'd5};
        re_b = 4'b0001; raddr_b = {15'd0, 5'd5};
        step();
        checks++;
        if (rdata !== {2{32'hDE22BE44}}) begin
            errors++;
            $display("FAIL bypass_merge: got %h want de22be44 x2", rdata);
        end
        checks++;
        if (rdata_b[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL nobypass_old: got %h want deadbeef", rdata_b[31:0]);
        end
        we = 0;
        step();
        checks++;
        if (rdata_b[31:0] !== 32'hDE22BE44 || rdata[31:0] !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL byte_enable_next: got %h/%h want de22be44", rdata[31:0], rdata_b[31:0]);
        end
        we = 1; wbe = 4'h0; wdata = 32'hFFFFFFFF;
        step();
        we = 0;
        step();
        checks++;
        if (rdata[31:0] !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL wbe_zero_noop: got %h want de22be44", rdata[31:0]);
        end
        idle();
    endtask

    task automatic test_zero_reg();
        idle();
        we = 1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wbe = 4'hF;
        re = 2'b11; raddr = 10'd0;
        re_b = 4'b0001; raddr_b = 20'd0;
        step();
        checks++;
        if (rdata !== 64'd0 || rdata_b[31:0] !== 32'd0) begin
            errors++;
            $display("FAIL zero_same_cycle: got %h/%h want 0", rdata, rdata_b[31:0]);
        end
        we = 0;
        step();
        checks++;
        if (rdata !== 64'd0 || rdata_b[31:0] !== 32'd0) begin
            errors++;
            $display("FAIL zero_later: got %h/%h want 0", rdata, rdata_b[31:0]);
        end
        idle();
    endtask

    task automatic test_enable_hold();
        write(5'd7, 32'hA5A50007, 4'hF);
        re = 2'b11; raddr = {5'd7, 5'd5};
        step();
        checks++;
        if (rdata !== {32'hA5A50007, 32'hDE22BE44}) begin
            errors++;
            $display("FAIL hold_setup: got %h want a5a50007de22be44", rdata);
        end
        re = 2'b01; raddr = {5'd5, 5'd7};
        step();
        checks++;
        if (rdata !== {32'hA5A50007, 32'hA5A50007}) begin
            errors++;
            $display("FAIL enable_hold: got %h want a5a50007a5a50007", rdata);
        end
        idle();
    endtask

    task automatic test_four_ports();
        for (int a = 1; a <= 4; a++) write(a[4:0], 32'h10000000 + a * 32'h111, 4'hF);
        re_b = 4'b1111; raddr_b = {5'd4, 5'd3, 5'd2, 5'd1};
        step();
        checks++;
        if (rdata_b !== {32'h10000444, 32'h10000333, 32'h10000222, 32'h10000111}) begin
            errors++;
            $display("FAIL four_ports: got %h want 10000444100003331000022210000111", rdata_b);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        #2 rst = 1;
        #1;
        checks++;
        if (rdata !== 64'd0 || rdata_b !== 128'd0 || ready !== 1'b0 || ready_b !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got ready=%b rdata=%h want 0", ready, rdata);
        end
        step();
        rst = 0;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear_ready: got %b want 0", ready);
        end
        rst = 1;
        step();
        rst = 0;
        wait_clear("reclear");
        read_all_zero("reclear_read", 7);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_zero_reg();
        test_enable_hold();
        test_four_ports();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_read_port_ram.md
# multi_read_port_ram

Parametrised register-file RAM: one byte-enabled write port, NRD independent registered read ports, with optional write-to-read bypass and an optional hard-wired zero entry. After reset, a built-in clear sequencer zeroes every entry before the block accepts traffic. It is the next-generation register file and scratch RAM for the core. Read data is registered, so it can be retimed against the pipeline's decode and execute stages.

## Interface

Parameters:
- DW, default 32: data width in bits; must be a multiple of 8.
- AW, default 5: address width; depth = 2^AW.
- NRD, default 2: number of read ports, 1..8.
- BYPASS, default 1: 1 = a same-cycle write is forwarded to a matching read; 0 = the read returns the old contents.
- ZERO_REG0, default 1: 1 = entry 0 is read-only zero.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_we  in  1  write enable.
- i_waddr  in  AW  write address.
- i_wdata  in  DW  write data.
- i_wbe  in  DW/8  byte enables; bit b covers i_wdata[8b+7:8b].
- i_re  in  NRD  per-port read enable.
- i_raddr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- o_rdata  out  NRD*DW  packed registered read data; port k uses bits [k*DW +: DW].
- o_ready  out  1  high once the clear sequence is complete.

## Operation

- Reset (asynchronous, rst=1):
  - o_rdata goes to all zeros and o_ready goes to 0.
  - The clear counter goes to 0 and the state goes to CLEAR.
  - The array itself is not reset.
- State CLEAR:
  - Each cycle, writes all-zeros to entry clr_cnt, then increments clr_cnt.
  - After entry 2^AW-1 is written, moves to READY.
  - User writes are ignored. o_rdata holds 0 regardless of i_re.
- State READY:
  - Write: if i_we, every byte b with i_wbe[b]=1 is updated in entry i_waddr. Other bytes keep their value.
  - i_we with i_wbe=0 is a no-op.
  - ZERO_REG0=1 and i_waddr=0: the write is dropped.
  - Read port k: if i_re[k], o_rdata[k] <= entry i_raddr[k]. If i_re[k]=0, o_rdata[k] holds its value.
  - ZERO_REG0=1 and i_raddr[k]=0: the port returns 0.
- Bypass (BYPASS=1, i_we, i_waddr==i_raddr[k], i_re[k], address not zero-locked):
  - Port k returns the merged word: new bytes where i_wbe=1, stored bytes elsewhere.
  - With BYPASS=0 the port returns the pre-write contents.
- Ports are fully independent. Any number of ports may read the same address in the same cycle.
- READY is terminal until the next rst.

## Timing

- Read latency is 1 cycle: address and i_re sampled at edge N give data at o_rdata after edge N.
- Write-to-read latency:
  - BYPASS=1: 0 cycles; a read in the same cycle as the write sees the new data.
  - BYPASS=0: a read issued in the cycle after the write sees the new data.
- Clear duration: after rst falls, the first edge writes entry 0. o_ready rises after edge 2^AW, which is 32 edges for AW=5.
- o_ready is registered and goes high in the same edge that enters READY. The first accepted access is in the cycle after o_ready is seen high.
- Reset mid-CLEAR or mid-READY aborts everything immediately. Clearing restarts from entry 0, and o_ready drops asynchronously.
- No combinational path from any input to any output.

## Structure

- Shared package (header of localparams):
  - state encodings ST_CLEAR=1'b0, ST_READY=1'b1.
  - the DW/8 byte-count helper.
  - limits on the NRD range.
- Top level holds:
  - the array (reg [DW-1:0] mem [0:2^AW-1]).
  - the write port with byte-merge logic.
  - the clear FSM and clr_cnt (AW+1 bits, so the terminal count is detectable).
- Sub-module ram_read_port, instantiated NRD times in a generate loop:
  - contains the output register, the enable hold, the zero-lock and the bypass merge.
  - takes the array word, the write bundle and the state as inputs.

## Test plan

- Reset then idle, defaults:
  - o_ready=0 for exactly 32 cycles after rst falls, then 1.
  - Reading all addresses on both ports returns 0.
- Write 0xDEADBEEF to addr 5 with wbe=4'hF, then read addr 5 on both ports the next cycle: both return 0xDEADBEEF one cycle later.
- Byte-enable write, addr 5 holding 0xDEADBEEF, write 0x11223344 with wbe=4'b0101:
  - BYPASS=1, same-cycle read of addr 5 returns 0xDE22BE44.
  - BYPASS=0 build: the same-cycle read returns 0xDEADBEEF, and the next read returns 0xDE22BE44.
- ZERO_REG0: write 0xFFFFFFFF to addr 0, then read addr 0 with the write held in the same cycle: returns 0, and also 0 later.
- Enable hold: i_re=2'b01 while the port-1 address changes, so o_rdata port 1 holds its prior value. NRD=4 build: four simultaneous distinct reads return correct data.
- Reset mid-operation:
  - Assert rst 10 cycles into CLEAR: o_ready stays 0 and the clear restarts, taking a full 32 cycles after release.
  - Assert rst in READY after writes: o_rdata=0 immediately, and all entries read 0 after the re-clear.
